// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
//
// Sweeps every N-bit input vector through two externally supplied
// combinational functions. One is the unminimised sum-of-minterms form and
// the other is its minimised form. For each vector the block captures the
// reference output into a truth table and counts its ones. It also counts
// disagreements between the two forms, skipping vectors marked don't-care,
// and records the lowest disagreeing vector.
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   rst           in   asynchronous, active-high reset
//   start         in   one-cycle request to begin a sweep (ignored mid-sweep)
//   vec           out  [N-1:0]  vector presented to both functions
//   s_ref         in   reference (sum-of-minterms) output for vec
//   s_min         in   minimised-function output for vec
//   dc            in   [2**N-1:0] don't-care mask, bit k exempts vector k
//   busy          out  high while sweeping
//   done          out  high from sweep completion until next start/reset
//   equal         out  high when done and no counted mismatch occurred
//   minterms      out  [2**N-1:0] captured truth table of s_ref
//   ones_cnt      out  [N:0]    vectors where s_ref = 1
//   mismatch_cnt  out  [N:0]    non-don't-care vectors where s_ref != s_min
//   first_bad     out  [N-1:0]  lowest vector with a counted mismatch
//   first_bad_vld out  first_bad holds a captured value
// ---------------------------------------------------------------------------
module truth_table_checker #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N-1:0]      vec,
    input  logic              s_ref,
    input  logic              s_min,
    input  logic [2**N-1:0]   dc,
    output logic              busy,
    output logic              done,
    output logic              equal,
    output logic [2**N-1:0]   minterms,
    output logic [N:0]        ones_cnt,
    output logic [N:0]        mismatch_cnt,
    output logic [N-1:0]      first_bad,
    output logic              first_bad_vld
);

    localparam int          NVEC = 1 << N;
    localparam logic [N-1:0] LAST = N'(NVEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   clear;      // wipe results and restart the vector counter
    logic   sample;     // capture this cycle's s_ref/s_min against vec
    logic   mism;       // counted mismatch at the current vector

    // A disagreement only counts when the vector is not a don't-care.
    assign mism = (s_ref != s_min) && !dc[vec];

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                // start is deliberately not looked at here
                sample = 1'b1;
                if (vec == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = SWEEP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            vec           <= '0;
            minterms      <= '0;
            ones_cnt      <= '0;
            mismatch_cnt  <= '0;
            first_bad     <= '0;
            first_bad_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                vec           <= '0;
                minterms      <= '0;
                ones_cnt      <= '0;
                mismatch_cnt  <= '0;
                first_bad     <= '0;
                first_bad_vld <= 1'b0;
            end else if (sample) begin
                minterms[vec] <= s_ref;
                ones_cnt      <= ones_cnt + (N+1)'(s_ref);
                // vec wraps to 0 naturally after the last vector
                vec           <= vec + N'(1);
                if (mism) begin
                    mismatch_cnt <= mismatch_cnt + (N+1)'(1);
                    // vectors are visited in ascending order, so the first
                    // captured mismatch is also the lowest one
                    if (!first_bad_vld) begin
                        first_bad     <= vec;
                        first_bad_vld <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy  = (state == SWEEP);
    assign done  = (state == DONE);
    assign equal = (state == DONE) && (mismatch_cnt == '0);

endmodule
